// File: rtl/popcount_batch_ctrl_pkg.sv
// Shared types and helpers for the popcount batch controller.
package popcount_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GO,
        WAIT_CLR,
        WAIT_DONE,
        EMIT
    } state_t;

    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/popcount_batch_ctrl.sv
// Batch controller around a go/done count-ones unit: feeds one word at a time,
// accumulates BATCH_LEN popcounts and emits a total, aborting on a hung counter.
module popcount_batch_ctrl
    import popcount_pkg::*;
#(
    parameter int unsigned INPUT_WIDTH = 32,
    parameter int unsigned BATCH_LEN   = 16,
    parameter int unsigned TIMEOUT     = INPUT_WIDTH * 5,
    localparam int unsigned CNT_WIDTH  = cnt_width(INPUT_WIDTH),
    localparam int unsigned SUM_WIDTH  = $clog2(INPUT_WIDTH * BATCH_LEN + 1),
    localparam int unsigned WCNT_WIDTH = $clog2(BATCH_LEN + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INPUT_WIDTH-1:0] in_data,
    output logic                   cnt_go,
    output logic [INPUT_WIDTH-1:0] cnt_in,
    input  logic                   cnt_done,
    input  logic [CNT_WIDTH-1:0]   cnt_out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SUM_WIDTH-1:0]   out_sum,
    output logic [WCNT_WIDTH-1:0]  out_words,
    output logic                   out_err
);

    localparam int unsigned TMR_WIDTH = $clog2(TIMEOUT + 1);

    state_t                  state, state_nx;
    logic [INPUT_WIDTH-1:0]  word_r;
    logic [SUM_WIDTH-1:0]    sum;
    logic [WCNT_WIDTH-1:0]   words;
    logic [TMR_WIDTH-1:0]    timer;
    logic                    err;
    logic                    last_word;
    logic                    expired;

    assign last_word = (words == WCNT_WIDTH'(BATCH_LEN - 1));
    assign expired   = (timer == TMR_WIDTH'(TIMEOUT - 1));

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (in_valid) state_nx = GO;
            GO:        state_nx = WAIT_CLR;
            WAIT_CLR:  state_nx = WAIT_DONE;
            WAIT_DONE: begin
                if (cnt_done)     state_nx = last_word ? EMIT : IDLE;
                else if (expired) state_nx = EMIT;
            end
            EMIT:      if (out_ready) state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // done takes priority over watchdog expiry in the same cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_r <= '0;
            sum    <= '0;
            words  <= '0;
            timer  <= '0;
            err    <= 1'b0;
        end else begin
            case (state)
                IDLE:      if (in_valid) word_r <= in_data;
                GO:        timer <= '0;
                WAIT_CLR:  timer <= timer + TMR_WIDTH'(1);
                WAIT_DONE: begin
                    if (cnt_done) begin
                        sum   <= sum + SUM_WIDTH'(cnt_out);
                        words <= words + WCNT_WIDTH'(1);
                    end else if (expired) begin
                        err <= 1'b1;
                    end else begin
                        timer <= timer + TMR_WIDTH'(1);
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        sum   <= '0;
                        words <= '0;
                        err   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign cnt_go    = (state == GO);
    assign cnt_in    = word_r;
    assign out_valid = (state == EMIT);
    assign out_sum   = sum;
    assign out_words = words;
    assign out_err   = err;

endmodule

// File: tb/tb_popcount_batch_ctrl.sv
// Bench for popcount_batch_ctrl: two instances (BATCH_LEN 4 and 1), each with a
// behavioural go/done counter and a batch-level scoreboard checked every cycle.
module tb_popcount_batch_ctrl;

    localparam int unsigned TO = 160;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid_a  [2];
    logic [31:0] in_data_a   [2];
    logic        out_ready_a [2];
    int unsigned lat_a       [2];
    logic        hang_a      [2];
    logic        stale_a     [2];
    logic [1:0]  rdy_v, ov_v;
    int          errors = 0;
    int          checks = 0;
    logic        run;

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : h
        localparam int unsigned BL = (g == 0) ? 4 : 1;
        localparam int unsigned SW = $clog2(32 * BL + 1);
        localparam int unsigned WW = $clog2(BL + 1);

        logic          in_ready, cnt_go, cnt_done, out_valid, out_err;
        logic [31:0]   cnt_in;
        logic [5:0]    cnt_out;
        logic [SW-1:0] out_sum;
        logic [WW-1:0] out_words;

        popcount_batch_ctrl #(
            .INPUT_WIDTH(32),
            .BATCH_LEN  (BL),
            .TIMEOUT    (TO)
        ) dut (
            .clk      (clk),
            .rst      (rst),
            .in_valid (in_valid_a[g]),
            .in_ready (in_ready),
            .in_data  (in_data_a[g]),
            .cnt_go   (cnt_go),
            .cnt_in   (cnt_in),
            .cnt_done (cnt_done),
            .cnt_out  (cnt_out),
            .out_valid(out_valid),
            .out_ready(out_ready_a[g]),
            .out_sum  (out_sum),
            .out_words(out_words),
            .out_err  (out_err)
        );

        assign rdy_v[g] = in_ready;
        assign ov_v[g]  = out_valid;

        // Behavioural counter: done stays high until the next go; in stale mode
        // it lingers one more cycle with the old result.
        int unsigned lat_q, left;
        logic        hang_q, stale_q, busy, clr_p;
        logic [31:0] cw;

        always @(posedge clk)
            if (in_valid_a[g] && in_ready) begin
                lat_q   <= lat_a[g];
                hang_q  <= hang_a[g];
                stale_q <= stale_a[g];
            end

        always @(posedge clk or negedge rst) begin
            if (!rst) begin
                cnt_done <= 1'b0;
                cnt_out  <= '0;
                busy     <= 1'b0;
                clr_p    <= 1'b0;
                left     <= 0;
                cw       <= '0;
            end else if (cnt_go) begin
                cw   <= cnt_in;
                busy <= 1'b1;
                left <= lat_q;
                if (stale_q) clr_p <= 1'b1;
                else         cnt_done <= 1'b0;
            end else begin
                if (clr_p) begin
                    cnt_done <= 1'b0;
                    clr_p    <= 1'b0;
                end
                if (busy && !hang_q) begin
                    if (left == 0) begin
                        cnt_done <= 1'b1;
                        cnt_out  <= 6'($countones(cw));
                        busy     <= 1'b0;
                    end else begin
                        left <= left - 1;
                    end
                end
            end
        end

        // Scoreboard: a word counts iff its counter latency fits the watchdog
        // window (done visible no later than the TO-2'th WAIT cycle).
        typedef struct packed {
            logic [7:0] s;
            logic [2:0] w;
            logic       e;
        } res_t;

        res_t        q[$];
        int unsigned acc_s = 0, acc_w = 0, n_push = 0, n_pop = 0, pending = 0;
        logic        prev_acc = 1'b0;
        logic [31:0] last_w = '0;
        logic        ok;

        always @(negedge clk) begin
            if (!rst) begin
                q.delete();
                acc_s    = 0;
                acc_w    = 0;
                prev_acc = 1'b0;
                last_w   = '0;
            end else begin
                chk($sformatf("u%0d cnt_go", g), cnt_go, prev_acc);
                chk($sformatf("u%0d cnt_in", g), cnt_in, last_w);
                if (out_valid) begin
                    chk($sformatf("u%0d in_ready_in_emit", g), in_ready, 0);
                    chk($sformatf("u%0d result_expected", g), q.size() != 0, 1);
                    if (q.size() != 0) begin
                        chk($sformatf("u%0d out_sum", g), out_sum, q[0].s);
                        chk($sformatf("u%0d out_words", g), out_words, q[0].w);
                        chk($sformatf("u%0d out_err", g), out_err, q[0].e);
                        if (out_ready_a[g]) begin
                            void'(q.pop_front());
                            n_pop++;
                        end
                    end
                end
                prev_acc = in_valid_a[g] && in_ready;
                if (prev_acc) begin
                    last_w = in_data_a[g];
                    ok = !hang_a[g] && (lat_a[g] <= TO - 2);
                    if (ok) begin
                        acc_s += $countones(in_data_a[g]);
                        acc_w++;
                    end
                    if (!ok || acc_w == BL) begin
                        q.push_back('{s: 8'(acc_s), w: 3'(acc_w), e: !ok});
                        n_push++;
                        acc_s = 0;
                        acc_w = 0;
                    end
                end
            end
            pending = q.size();
        end
    end

    task automatic send(input int g, input logic [31:0] w, input int unsigned l);
        int n = 0;
        @(posedge clk); #1;
        lat_a[g]      = l;
        in_data_a[g]  = w;
        in_valid_a[g] = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!rdy_v[g] && n < 400);
        chk($sformatf("u%0d accept", g), rdy_v[g], 1);
        @(posedge clk); #1;
        in_valid_a[g] = 1'b0;
    endtask

    task automatic wait_out(input int g, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!ov_v[g] && cyc < 400);
        chk($sformatf("u%0d out_valid_seen", g), ov_v[g], 1);
    endtask

    task automatic take(input int g);
        @(posedge clk); #1;
        out_ready_a[g] = 1'b1;
        @(posedge clk); #1;
        out_ready_a[g] = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " in_ready"},  h[0].in_ready, 1);
        chk({tag, " cnt_go"},    h[0].cnt_go, 0);
        chk({tag, " out_valid"}, h[0].out_valid, 0);
        chk({tag, " out_sum"},   h[0].out_sum, 0);
        chk({tag, " out_words"}, h[0].out_words, 0);
        chk({tag, " out_err"},   h[0].out_err, 0);
        chk({tag, " cnt_in"},    h[0].cnt_in, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc, n;
        int unsigned l;
        logic        s;
        rst = 1'b0;
        run = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid_a[i]  = 1'b0;
            in_data_a[i]   = '0;
            out_ready_a[i] = 1'b0;
            lat_a[i]       = 0;
            hang_a[i]      = 1'b0;
            stale_a[i]     = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1 chk_reset_vals("por");
        @(posedge clk); #1 rst = 1'b1;

        // Mixed latencies, two with a stale done; then hold the result 10 cycles
        send(0, 32'h0000_0000, 0);
        stale_a[0] = 1'b1;
        send(0, 32'h0000_0001, 1);
        send(0, 32'hFFFF_FFFF, 2);
        stale_a[0] = 1'b0;
        send(0, 32'hF0F0_F0F0, 3);
        wait_out(0, cyc);
        chk("t1 sum", h[0].out_sum, 49);
        chk("t1 words", h[0].out_words, 4);
        chk("t1 err", h[0].out_err, 0);
        repeat (10) @(negedge clk);
        chk("t2 held out_valid", h[0].out_valid, 1);
        chk("t2 held in_ready", h[0].in_ready, 0);
        chk("t2 held sum", h[0].out_sum, 49);
        take(0);
        @(negedge clk);
        chk("t2 back to idle", h[0].in_ready, 1);

        // Hung counter after two words: abort 161 cycles after the go pulse
        send(0, 32'h0000_00FF, 2);
        send(0, 32'h0000_0003, 0);
        hang_a[0] = 1'b1;
        send(0, 32'h0000_0005, 0);
        wait_out(0, cyc);
        chk("t3 abort latency", cyc, 162);
        chk("t3 sum", h[0].out_sum, 10);
        chk("t3 words", h[0].out_words, 2);
        chk("t3 err", h[0].out_err, 1);
        take(0);
        hang_a[0] = 1'b0;

        // Done on the expiry cycle wins; one cycle later loses
        send(0, 32'h0000_0001, TO - 2);
        send(0, 32'h0000_0007, TO - 1);
        wait_out(0, cyc);
        chk("t3b sum", h[0].out_sum, 1);
        chk("t3b words", h[0].out_words, 1);
        chk("t3b err", h[0].out_err, 1);
        take(0);

        // Asynchronous reset while waiting for done
        send(0, 32'h0000_00AB, 50);
        repeat (5) @(negedge clk);
        @(posedge clk); #2 rst = 1'b0;
        #1 chk_reset_vals("mid_reset");
        @(posedge clk); #1 rst = 1'b1;
        send(0, 32'h0000_000F, 1);
        send(0, 32'h0000_00FF, 1);
        send(0, 32'h0000_0000, 1);
        send(0, 32'h8000_0000, 1);
        wait_out(0, cyc);
        chk("t4 sum", h[0].out_sum, 13);
        chk("t4 words", h[0].out_words, 4);
        take(0);

        // Random stalls on both sides, 500 batches
        run = 1'b1;
        fork
            begin
                for (int b = 0; b < 500 * 4; b++) begin
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    s = 1'($urandom_range(0, 1));
                    l = s ? $urandom_range(1, 3) : $urandom_range(0, 3);
                    stale_a[0] = s;
                    send(0, $urandom, l);
                end
                run = 1'b0;
            end
            begin
                while (run) begin
                    @(posedge clk); #1;
                    out_ready_a[0] = 1'($urandom_range(0, 1));
                end
            end
        join
        stale_a[0] = 1'b0;
        @(posedge clk); #1 out_ready_a[0] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((h[0].pending != 0 || h[0].out_valid) && n < 200);
        @(posedge clk); #1 out_ready_a[0] = 1'b0;

        // BATCH_LEN=1: pinned first result, then 1000 streamed words
        send(1, 32'hFFFF_0000, 0);
        wait_out(1, cyc);
        chk("t5 pin sum", h[1].out_sum, 16);
        chk("t5 pin words", h[1].out_words, 1);
        take(1);
        @(posedge clk); #1;
        out_ready_a[1] = 1'b1;
        in_valid_a[1]  = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            in_data_a[1] = $urandom;
            lat_a[1]     = $urandom_range(0, 3);
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!rdy_v[1] && n < 400);
            chk("t5 accept", rdy_v[1], 1);
            @(posedge clk); #1;
        end
        in_valid_a[1] = 1'b0;
        repeat (20) @(negedge clk);

        chk("u0 pending", h[0].pending, 0);
        chk("u0 results", h[0].n_pop, 504);
        chk("u1 pending", h[1].pending, 0);
        chk("u1 results", h[1].n_pop, 1001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
